// File: rtl/dadd_pkg.sv
// rtl/dadd_pkg.sv - field map, op encoding and result function for the data-add pipe
// Contents:
//   DADD_*_BIT / DADD_ADDEND_*  bit positions inside the 32-bit reg_value word
//   dadd_op_e                   add/subtract selector
//   dadd_calc()                 one beat's result from (data, cfg, data width)
// Build option: DADD_PIPE_SAT_EN enables saturation on carry/borrow.
package dadd_pkg;

  localparam int unsigned DADD_EN_BIT     = 0;
  localparam int unsigned DADD_OP_BIT     = 1;
  localparam int unsigned DADD_SAT_BIT    = 2;
  localparam int unsigned DADD_ADDEND_LSB = 3;
  localparam int unsigned DADD_ADDEND_W   = 7;

  // Widest data path the shared function supports.
  localparam int unsigned DADD_MAX_DW = 64;

  typedef enum logic {
    DADD_OP_ADD = 1'b0,
    DADD_OP_SUB = 1'b1
  } dadd_op_e;

  typedef logic [DADD_MAX_DW-1:0] dadd_word_t;
  typedef logic [DADD_MAX_DW:0]   dadd_wide_t;

  // data must be zero above bit dw-1. The arithmetic keeps one extra bit
  // so a carry out of the dw-bit field is visible before masking.
  function automatic dadd_word_t dadd_calc(input dadd_word_t  data,
                                           input logic [31:0] cfg,
                                           input int unsigned dw);
    dadd_wide_t mask;
    dadd_wide_t addend;
    dadd_wide_t res;
    dadd_op_e   op;
    mask   = {(DADD_MAX_DW+1){1'b1}} >> (DADD_MAX_DW + 1 - dw);
    addend = '0;
    addend[DADD_ADDEND_W-1:0] = cfg[DADD_ADDEND_LSB +: DADD_ADDEND_W];
    op     = dadd_op_e'(cfg[DADD_OP_BIT]);
    if (!cfg[DADD_EN_BIT]) begin
      res = {1'b0, data};
    end else if (op == DADD_OP_ADD) begin
      res = {1'b0, data} + addend;
    end else begin
      res = {1'b0, data} - addend;
    end
`ifdef DADD_PIPE_SAT_EN
    if (cfg[DADD_EN_BIT] && cfg[DADD_SAT_BIT]) begin
      if (op == DADD_OP_ADD && (res & ~mask) != '0) begin
        res = mask;
      end else if (op == DADD_OP_SUB && {1'b0, data} < addend) begin
        res = '0;
      end
    end
`endif
    res = res & mask;
    return res[DADD_MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/dadd_fifo.sv
// rtl/dadd_fifo.sv - synchronous FIFO with occupancy count
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset (flushes all)
//   push, wdata   write one entry (ignored when full with no simultaneous pop)
//   pop           remove head (ignored when empty)
//   rdata         head entry; holds the last popped entry while empty
//   level         number of stored entries, 0..DEPTH
module dadd_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

  // Once empty, show the entry that just left rather than a stale slot.
  assign rdata = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign level = level_q;

endmodule

// File: rtl/dadd_data_pipe.sv
// rtl/dadd_data_pipe.sv - flow-controlled add/subtract stage feeding an output FIFO
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_data, in_addr carried with the beat
//   reg_value                per-beat config sampled at accept:
//                            [0] enable, [1] op (0 add, 1 sub), [2] saturate, [9:3] addend
//   out_valid/out_ready      output handshake; out_data, out_addr are the FIFO head
//   level                    FIFO occupancy
// Build option: DADD_PIPE_SAT_EN builds saturation; otherwise results always wrap.
module dadd_data_pipe
  import dadd_pkg::*;
#(
  parameter int unsigned LOC_AWIDTH = 32,
  parameter int unsigned LOC_DWIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LOC_DWIDTH-1:0]         in_data,
  input  logic [LOC_AWIDTH-1:0]         in_addr,
  input  logic [31:0]                   reg_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LOC_DWIDTH-1:0]         out_data,
  output logic [LOC_AWIDTH-1:0]         out_addr,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = LOC_AWIDTH + LOC_DWIDTH;

  logic                  stg_v_q, stg_v_d;
  logic [LOC_DWIDTH-1:0] stg_data_q, stg_data_d;
  logic [LOC_AWIDTH-1:0] stg_addr_q, stg_addr_d;

  logic                  accept;
  logic [LW-1:0]         credit_used;
  dadd_word_t            data_ext;
  dadd_word_t            calc_full;
  logic [FW-1:0]         fifo_rdata;

  // A beat in the stage register has already claimed a FIFO slot, so it
  // counts against the credit limit. Only registered state feeds this.
  assign credit_used = level + LW'(stg_v_q);
  assign in_ready    = !rst && (credit_used < LW'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;

  always_comb begin
    data_ext                 = '0;
    data_ext[LOC_DWIDTH-1:0] = in_data;
    calc_full                = dadd_calc(data_ext, reg_value, LOC_DWIDTH);
  end

  generate
    if (LOC_DWIDTH < DADD_MAX_DW) begin : g_hi
      logic calc_hi_unused;
      assign calc_hi_unused = ^calc_full[DADD_MAX_DW-1:LOC_DWIDTH];
    end
  endgenerate

  always_comb begin
    stg_v_d    = accept;
    stg_data_d = stg_data_q;
    stg_addr_d = stg_addr_q;
    if (accept) begin
      stg_data_d = calc_full[LOC_DWIDTH-1:0];
      stg_addr_d = in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_v_q    <= 1'b0;
      stg_data_q <= '0;
      stg_addr_q <= '0;
    end else begin
      stg_v_q    <= stg_v_d;
      stg_data_q <= stg_data_d;
      stg_addr_q <= stg_addr_d;
    end
  end

  dadd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stg_v_q),
    .wdata ({stg_addr_q, stg_data_q}),
    .pop   (out_valid && out_ready),
    .rdata (fifo_rdata),
    .level (level)
  );

  assign out_valid = (level != '0);
  assign out_data  = fifo_rdata[LOC_DWIDTH-1:0];
  assign out_addr  = fifo_rdata[FW-1:LOC_DWIDTH];

endmodule

// File: tb/tb_dadd_data_pipe.sv
// tb/tb_dadd_data_pipe.sv - directed self-checking bench for dadd_data_pipe
module tb_dadd_data_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [31:0] reg_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  dadd_data_pipe #(
    .LOC_AWIDTH (32),
    .LOC_DWIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .reg_value (reg_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] cfg,
                         input logic [31:0] exp);
    in_addr   = addr;
    in_data   = data;
    reg_value = cfg;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_ready"}, in_ready, 1'b1);
    tick();
    in_valid  = 1'b0;
    reg_value = ~cfg;
    in_data   = ~data;
    chk({tag, "_lat1_valid"}, out_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_addr"}, out_addr, addr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_level_after_pop"}, level, 3'd0);
    chk({tag, "_empty_hold"}, out_data, exp);
  endtask

  logic [31:0] exp_q[$];
  int          acc;
  int          sent;
  int          got;
  int          stalls;
  int          seen;
  logic        accept_now;
  logic [31:0] stream_exp [6];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    reg_value = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_level", level, 3'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    tick();
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_out_data", out_data, 32'h0);
    chk("idle_out_addr", out_addr, 32'h0);
    chk("idle_level", level, 3'd0);
    chk("idle_in_ready", in_ready, 1'b1);

    run_one("add", 32'h0000_00A0, 32'h0000_0010, 32'h101, 32'h0000_0030);
`ifdef DADD_PIPE_SAT_EN
    run_one("sat_add", 32'h0000_00A4, 32'hFFFF_FFF0, 32'h105, 32'hFFFF_FFFF);
    run_one("sat_sub", 32'h0000_00A8, 32'h0000_0005, 32'h03F, 32'h0000_0000);
`else
    run_one("sat_add", 32'h0000_00A4, 32'hFFFF_FFF0, 32'h105, 32'h0000_0010);
    run_one("sat_sub", 32'h0000_00A8, 32'h0000_0005, 32'h03F, 32'hFFFF_FFFE);
`endif
    run_one("sub_wrap", 32'h0000_00AC, 32'h0000_0005, 32'h03B, 32'hFFFF_FFFE);
    run_one("disabled", 32'h0000_00B0, 32'h0000_1234, 32'h102, 32'h0000_1234);
    run_one("add_max", 32'h0000_00B4, 32'hFFFF_FFFF, 32'h3F9, 32'h0000_007E);

    // Pop attempt while empty is ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_pop_level", level, 3'd0);
    chk("empty_pop_valid", out_valid, 1'b0);

    // Backpressure: fill with out_ready low.
    reg_value = 32'h9;
    in_valid  = 1'b1;
    acc       = 0;
    for (int i = 0; i < 8; i++) begin
      in_data    = 32'h200 + acc;
      in_addr    = 32'h1000 + acc * 4;
      accept_now = in_ready;
      if (accept_now) exp_q.push_back(32'h201 + acc);
      tick();
      if (accept_now) acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_level", level, 3'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_data", out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
      chk("drain_addr", out_addr, 32'h1000 + i * 4);
      tick();
      if (i == 0) chk("drain_ready_back", in_ready, 1'b1);
    end
    out_ready = 1'b0;
    chk("drain_level", level, 3'd0);
    chk("drain_valid_end", out_valid, 1'b0);
    chk("drain_hold_last", out_data, 32'h204);

    // Full-rate stream with config alternating every beat.
    stream_exp = '{32'h120, 32'h100, 32'h122, 32'h102, 32'h124, 32'h104};
    sent      = 0;
    got       = 0;
    stalls    = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      if (sent < 6) begin
        in_valid  = 1'b1;
        in_data   = 32'h100 + sent;
        in_addr   = 32'h2000 + sent;
        reg_value = (sent % 2 == 1) ? 32'h0B : 32'h101;
      end else begin
        in_valid  = 1'b0;
      end
      accept_now = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin
        chk("stream_data", out_data, stream_exp[got]);
        chk("stream_addr", out_addr, 32'h2000 + got);
        got++;
      end
      tick();
      if (accept_now) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_count", got, 6);
    chk("stream_stalls", stalls, 0);

    // Reset with three beats buffered.
    reg_value = 32'h101;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + i;
      in_addr  = 32'h3000 + i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_rst_level", level, 3'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    chk("mid_rst_level", level, 3'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("no_stale_beats", seen, 0);
    chk("post_flush_ready", in_ready, 1'b1);
    run_one("after_flush", 32'h0000_00C0, 32'h0000_0040, 32'h101, 32'h0000_0060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dadd_data_pipe.md
# dadd_data_pipe

Parametrised, flow-controlled successor to the single-stage data-add datapath. It takes address/data beats over a valid/ready handshake and applies a per-beat add or subtract of a 7-bit addend, with optional saturation. Results are buffered in an output FIFO with backpressure. It sits between the bus-side data source and the downstream writer, configured from the same 32-bit register word.

## Interface
- LOC_AWIDTH, 32, address width
- LOC_DWIDTH, 32, data width (≥8)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  LOC_DWIDTH  input data
- in_addr  in  LOC_AWIDTH  input address, passed through unchanged
- reg_value  in  32  config: [0] enable, [1] op (0 add, 1 sub), [2] saturate, [9:3] addend, rest reserved
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LOC_DWIDTH  result
- out_addr  out  LOC_AWIDTH  address of result
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Accept on in_valid && in_ready. reg_value is sampled in the same cycle and applies to that beat only, so mid-stream config changes never affect beats already accepted.
- Stage 1 (compute register, stg_v): result computed with a LOC_DWIDTH+1 intermediate.
  - enable=0: out = in_data.
  - add: in_data + zero-extended addend.
  - sub: in_data − zero-extended addend.
- Overflow/underflow:
  - saturate=1 (macro present): clamp to all-ones on add carry, to 0 on sub borrow.
  - Otherwise: modulo 2^LOC_DWIDTH.
- Stage 2: stg_v writes {addr,data} into the FIFO the next cycle. Writes always succeed, because credits guarantee space.
- Credit rule: in_ready = (level + stg_v) < FIFO_DEPTH, computed from registers only. There is no combinational path from out_ready to in_ready.
- Pop on out_valid && out_ready. out_valid = (level != 0). out_data/out_addr hold the head entry stable while out_valid && !out_ready.
- Ordering is strict FIFO. No beat is dropped or duplicated.

## Timing
- Reset values: in_ready=0 during rst, then 1 from the first cycle after rst deasserts. out_valid=0, out_data=0, out_addr=0, level=0, stg_v=0.
- Latency: a beat accepted at edge k into an empty FIFO has out_valid=1 after edge k+2.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous push and pop on the same edge: level unchanged, pointers both advance and wrap modulo FIFO_DEPTH.
- Full: level=FIFO_DEPTH, or level=FIFO_DEPTH−1 with stg_v=1, forces in_ready=0. in_ready reasserts the cycle after a pop frees a credit.
- Empty: out_valid=0 and out_data holds its last value. A pop attempt while empty is ignored.
- Reset mid-operation: the stage register and FIFO are flushed the same edge, and in-flight beats are discarded.

## Configuration
- DADD_PIPE_SAT_EN defined: reg_value[2] selects saturation as above.
- Not defined: saturation logic is not built, reg_value[2] is ignored, and arithmetic always wraps modulo 2^LOC_DWIDTH.

## Structure
- Package dadd_pkg holds:
  - Field bit positions: DADD_EN_BIT=0, DADD_OP_BIT=1, DADD_SAT_BIT=2, DADD_ADDEND_LSB=3, DADD_ADDEND_W=7.
  - Op enum: DADD_OP_ADD, DADD_OP_SUB.
  - A function computing the result from (data, cfg).
- One sub-module, dadd_fifo: synchronous FIFO parametrised on width and depth, with push/pop/level and registered pointers. The top holds the compute stage and credit logic.

## Test plan
- Reset then idle: after rst, out_valid=0, level=0, out_data=0; in_ready=1 on the first cycle after rst deasserts.
- Add path: reg_value=0x101, in_data=0x10 → out_data=0x30 at edge k+2, out_addr equal to the input address.
- Saturation (macro on): reg_value=0x105, in_data=0xFFFFFFF0 → 0xFFFFFFFF. Same stimulus with macro off → 0x00000010.
- Subtract: reg_value=0x3F, in_data=0x5 → 0x0 with the macro on, 0xFFFFFFFE with it off. reg_value=0x3B, in_data=0x5 → 0xFFFFFFFE.
- Backpressure: out_ready=0 with continuous in_valid → exactly FIFO_DEPTH beats accepted and in_ready=0. Then out_ready=1 → all beats emerge in order, and in_ready returns one cycle after the first pop.
- Config change and reset mid-stream: reg_value toggles between consecutive beats → each result uses the config present at its own accept. Asserting rst with 3 beats buffered → level=0 and out_valid=0 next cycle, and no stale beat is emitted afterwards.
